// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Serialises bitstream words LSB-first into the I/O tile ccff chain.
//            Optional parity readback is built when CCFF_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              bs_valid,
  input  logic [WORD_W-1:0] bs_data,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] C_CHAIN_LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] C_LAST_CNT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(WORD_W - 1);

`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1
  } state_t;
`endif

  state_t r_state;
  state_t w_next_state;

  logic [WORD_W-1:0] r_buf;
  logic              r_buf_valid;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_shift_cnt;
  logic [CNT_W-1:0]  r_acc_bits;
  logic              r_cfg_done;

  logic w_start;
  logic w_accept;
  logic w_shift;
  logic w_word_end;
  logic w_final;

`ifdef CCFF_READBACK_EN
  logic r_cfg_err;
  logic r_load_par;
  logic r_tail_par;
  logic w_verify;
  logic w_verify_last;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

  assign w_start  = start & (r_state == ST_IDLE);
  assign w_accept = bs_valid & bs_ready;

  // State register
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and chain-facing outputs
  always_comb begin
    w_next_state = r_state;
    bs_ready     = 1'b0;
    ccff_en      = 1'b0;
    ccff_head    = 1'b0;
    w_shift      = 1'b0;
    w_word_end   = 1'b0;
    w_final      = 1'b0;
`ifdef CCFF_READBACK_EN
    w_verify      = 1'b0;
    w_verify_last = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_shift    = r_buf_valid;
        w_word_end = r_buf_valid & (r_bit_idx == C_LAST_IDX);
        w_final    = r_buf_valid & (r_shift_cnt == C_LAST_CNT);
        ccff_en    = r_buf_valid;
        ccff_head  = r_buf_valid & r_buf[0];
        // Refill in the same cycle the last bit leaves, so words stream without a bubble
        bs_ready   = (!r_buf_valid || w_word_end) && (r_acc_bits < C_CHAIN_LEN);
        if (w_final) begin
`ifdef CCFF_READBACK_EN
          w_next_state = ST_VERIFY;
`else
          w_next_state = ST_IDLE;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
      ST_VERIFY: begin
        // Recirculate tail into head so the chain ends up unchanged
        w_verify      = 1'b1;
        w_verify_last = (r_shift_cnt == C_LAST_CNT);
        ccff_en       = 1'b1;
        ccff_head     = ccff_tail;
        if (w_verify_last) begin
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Word buffer, counters and completion flags
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_bit_idx   <= '0;
      r_shift_cnt <= '0;
      r_acc_bits  <= '0;
      r_cfg_done  <= 1'b0;
`ifdef CCFF_READBACK_EN
      r_cfg_err   <= 1'b0;
      r_load_par  <= 1'b0;
      r_tail_par  <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_buf_valid <= 1'b0;
        r_bit_idx   <= '0;
        r_shift_cnt <= '0;
        r_acc_bits  <= '0;
        r_cfg_done  <= 1'b0;
`ifdef CCFF_READBACK_EN
        r_cfg_err   <= 1'b0;
        r_load_par  <= 1'b0;
        r_tail_par  <= 1'b0;
`endif
      end

      if (w_accept) begin
        r_buf       <= bs_data;
        r_buf_valid <= 1'b1;
        r_bit_idx   <= '0;
        // Saturate at CHAIN_LEN; surplus bits of the last word are never shifted
        if (int'(r_acc_bits) + WORD_W >= CHAIN_LEN) begin
          r_acc_bits <= C_CHAIN_LEN;
        end else begin
          r_acc_bits <= r_acc_bits + CNT_W'(WORD_W);
        end
      end else if (w_shift) begin
        r_buf     <= r_buf >> 1;
        r_bit_idx <= r_bit_idx + IDX_W'(1);
        if (w_word_end) begin
          r_buf_valid <= 1'b0;
        end
      end

      if (w_shift) begin
        r_shift_cnt <= w_final ? '0 : r_shift_cnt + CNT_W'(1);
      end

      if (w_final) begin
        r_buf_valid <= 1'b0;
`ifndef CCFF_READBACK_EN
        r_cfg_done  <= 1'b1;
`endif
      end

`ifdef CCFF_READBACK_EN
      if (w_shift) begin
        r_load_par <= r_load_par ^ r_buf[0];
      end

      if (w_verify) begin
        r_tail_par <= r_tail_par ^ ccff_tail;
        if (w_verify_last) begin
          r_shift_cnt <= '0;
          r_cfg_done  <= (r_load_par == (r_tail_par ^ ccff_tail));
          r_cfg_err   <= (r_load_par != (r_tail_par ^ ccff_tail));
        end else begin
          r_shift_cnt <= r_shift_cnt + CNT_W'(1);
        end
      end
`endif
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign cfg_done = r_cfg_done;
`ifdef CCFF_READBACK_EN
  assign cfg_err  = r_cfg_err;
`else
  assign cfg_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// Directed bench for ccff_chain_loader: a 32-bit and a 12-bit chain instance,
// each driving a shift-register chain model.
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_EN
  localparam int EXP_EN32 = 64;
  localparam int EXP_EN12 = 24;
`else
  localparam int EXP_EN32 = 32;
  localparam int EXP_EN12 = 12;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       prog_reset;
  logic       start, bs_valid, bs_ready, ccff_head, ccff_en, ccff_tail, busy, cfg_done, cfg_err;
  logic [7:0] bs_data;
  logic       start12, valid12, ready12, head12, en12, tail12, busy12, done12, err12;
  logic [7:0] data12;
  logic       inv;

  ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start), .bs_valid(bs_valid),
    .bs_data(bs_data), .bs_ready(bs_ready), .ccff_head(ccff_head), .ccff_en(ccff_en),
    .ccff_tail(ccff_tail), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start12), .bs_valid(valid12),
    .bs_data(data12), .bs_ready(ready12), .ccff_head(head12), .ccff_en(en12),
    .ccff_tail(tail12), .busy(busy12), .cfg_done(done12), .cfg_err(err12)
  );

  // Chain models: head enters at the top, tail leaves from bit 0
  logic [31:0] chain32 = '0;
  logic [11:0] chain12 = '0;
  always @(posedge clk) begin
    if (ccff_en) chain32 <= {ccff_head, chain32[31:1]};
    if (en12)    chain12 <= {head12, chain12[11:1]};
  end
  assign ccff_tail = chain32[0] ^ inv;
  assign tail12    = chain12[0];

  // Monitors, sampled on the falling edge
  int          cyc = 0;
  int          n_en = 0, stalls = 0, stall_bad = 0;
  int          start_cyc = 0, first_en_cyc = 0, done_cyc = 0;
  logic        done_seen = 1'b0;
  logic [31:0] head_bits = '0;
  int          n_en12 = 0, acc12 = 0;
  logic [11:0] bits12 = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy) begin
      n_en <= 0; stalls <= 0; stall_bad <= 0; head_bits <= '0;
      start_cyc <= cyc; first_en_cyc <= -1; done_cyc <= -1; done_seen <= 1'b0;
    end else begin
      if (ccff_en) begin
        if (n_en < 32) head_bits[n_en] <= ccff_head;
        if (n_en == 0) first_en_cyc <= cyc;
        n_en <= n_en + 1;
      end else if (busy && n_en > 0) begin
        stalls <= stalls + 1;
        if (ccff_head) stall_bad <= stall_bad + 1;
      end
      if (cfg_done && !done_seen) begin
        done_seen <= 1'b1;
        done_cyc  <= cyc;
      end
    end
    if (start12 && !busy12) begin
      n_en12 <= 0; acc12 <= 0; bits12 <= '0;
    end else begin
      if (en12) begin
        if (n_en12 < 12) bits12[n_en12] <= head12;
        n_en12 <= n_en12 + 1;
      end
      if (valid12 && ready12) acc12 <= acc12 + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0][7:0] words;      // words[0] is sent first
    int              gap_idx;    // word preceded by a drained-buffer gap
    int              gap;
    logic [31:0]     exp_bits;   // expected head bit k at position k
    int              exp_stall;
  } vec_t;

  vec_t vecs[4];

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input int gap);
    logic rdy;
    logic got;
    got = 1'b0;
    if (gap > 0) begin
      rdy = 1'b0;
      for (int t = 0; t < 100 && !rdy; t++) begin
        @(negedge clk); rdy = bs_ready;
      end
      repeat (gap) @(posedge clk);
      #1;
    end
    bs_valid = 1'b1; bs_data = d;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk); rdy = bs_ready;
      @(posedge clk); got = rdy;
    end
    #1 bs_valid = 1'b0; bs_data = '0;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL send_word: word 0x%0h never accepted", d);
    end
  endtask

  task automatic send12(input logic [7:0] d);
    logic rdy;
    logic got;
    got = 1'b0;
    valid12 = 1'b1; data12 = d;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk); rdy = ready12;
      @(posedge clk); got = rdy;
    end
    #1 valid12 = 1'b0; data12 = '0;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL send12: word 0x%0h never accepted", d);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (busy && t < 400);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_en(input int n, input string tag);
    int t;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (n_en < n && t < 400);
    check({tag, "_reach_en"}, 64'(n_en >= n), 64'd1);
  endtask

  task automatic run_vector(input int i, input string tag);
    pulse_start();
    for (int k = 0; k < 4; k++)
      send_word(vecs[i].words[k], (k == vecs[i].gap_idx) ? vecs[i].gap : 0);
    wait_idle(tag);
    check({tag, "_head_bits"}, 64'(head_bits), 64'(vecs[i].exp_bits));
    check({tag, "_en_count"},  64'(n_en), 64'(EXP_EN32));
    check({tag, "_stalls"},    64'(stalls), 64'(vecs[i].exp_stall));
    check({tag, "_stall_head"}, 64'(stall_bad), 64'd0);
    check({tag, "_chain"},     64'(chain32), 64'(vecs[i].exp_bits));
    check({tag, "_done"},      64'(cfg_done), 64'd1);
    check({tag, "_err"},       64'(cfg_err), 64'd0);
    check({tag, "_first_lat"}, 64'(first_en_cyc - start_cyc), 64'd2);
    check({tag, "_done_lat"},  64'(done_cyc - first_en_cyc), 64'(EXP_EN32 + vecs[i].exp_stall));
  endtask

  task automatic run12(input logic [7:0] w0, input logic [7:0] w1, input logic [11:0] exp, input string tag);
    int t;
    @(posedge clk); #1 start12 = 1'b1;
    @(posedge clk); #1 start12 = 1'b0;
    send12(w0);
    send12(w1);
    valid12 = 1'b1; data12 = 8'hAA;   // extra word must be refused
    t = 0;
    do begin @(negedge clk); #1; t++; end while (busy12 && t < 200);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_idle"},     64'(busy12), 64'd0);
    check({tag, "_ready_off"}, 64'(ready12), 64'd0);
    valid12 = 1'b0; data12 = '0;
    check({tag, "_accepts"},  64'(acc12), 64'd2);
    check({tag, "_en_count"}, 64'(n_en12), 64'(EXP_EN12));
    check({tag, "_bits"},     64'(bits12), 64'(exp));
    check({tag, "_chain"},    64'(chain12), 64'(exp));
    check({tag, "_done"},     64'(done12), 64'd1);
    check({tag, "_err"},      64'(err12), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_reset = 1'b0; inv = 1'b0;
    start = 1'b0; bs_valid = 1'b0; bs_data = '0;
    start12 = 1'b0; valid12 = 1'b0; data12 = '0;

    vecs[0].words = {8'h00, 8'hFF, 8'h3C, 8'hA5}; vecs[0].gap_idx = 0; vecs[0].gap = 0;
    vecs[0].exp_bits = 32'h00FF3CA5; vecs[0].exp_stall = 0;
    vecs[1].words = {8'h00, 8'hFF, 8'h3C, 8'hA5}; vecs[1].gap_idx = 2; vecs[1].gap = 5;
    vecs[1].exp_bits = 32'h00FF3CA5; vecs[1].exp_stall = 5;
    vecs[2].words = {8'h78, 8'h56, 8'h34, 8'h12}; vecs[2].gap_idx = 0; vecs[2].gap = 0;
    vecs[2].exp_bits = 32'h78563412; vecs[2].exp_stall = 0;
    vecs[3].words = {8'hC3, 8'h7E, 8'h01, 8'h80}; vecs[3].gap_idx = 1; vecs[3].gap = 2;
    vecs[3].exp_bits = 32'hC37E0180; vecs[3].exp_stall = 2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs",   64'({bs_ready, ccff_en, ccff_head, busy, cfg_done, cfg_err}), 64'd0);
    check("reset_outs12", 64'({ready12, en12, head12, busy12, done12, err12}), 64'd0);
    @(negedge clk); prog_reset = 1'b1;

    // bs_valid outside LOAD is ignored
    @(posedge clk); #1 bs_valid = 1'b1; bs_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("idle_ignore%0d", k), 64'({bs_ready, ccff_en, busy, cfg_done}), 64'd0);
    end
    @(posedge clk); #1 bs_valid = 1'b0; bs_data = '0;

    for (int i = 0; i < 4; i++) run_vector(i, $sformatf("v%0d", i));

    // Start pulse while loading is ignored
    pulse_start();
    send_word(8'hA5, 0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    send_word(8'h3C, 0);
    send_word(8'hFF, 0);
    send_word(8'h00, 0);
    wait_idle("t6");
    check("t6_en_count",  64'(n_en), 64'(EXP_EN32));
    check("t6_head_bits", 64'(head_bits), 64'h00FF3CA5);
    check("t6_done",      64'(cfg_done), 64'd1);

    // Short chain: surplus bits of the last word dropped
    run12(8'hFF, 8'h0F, 12'hFFF, "t3a");
    run12(8'h5A, 8'h93, 12'h35A, "t3b");

    // Reset in the middle of a load
    pulse_start();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_en(10, "t4");
    prog_reset = 1'b0;
    #1;
    check("t4_reset_outs",   64'({bs_ready, ccff_en, ccff_head, busy, cfg_done, cfg_err}), 64'd0);
    check("t4_reset_outs12", 64'({ready12, en12, head12, busy12, done12, err12}), 64'd0);
    @(negedge clk); prog_reset = 1'b1;
    run_vector(0, "t4_reload");

`ifdef CCFF_READBACK_EN
    // Corrupt one tail bit during verify
    pulse_start();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    send_word(8'hFF, 0);
    send_word(8'h00, 0);
    wait_en(40, "t5");
    inv = 1'b1;
    @(posedge clk); #1 inv = 1'b0;
    wait_idle("t5_fault");
    check("t5_fault_done", 64'(cfg_done), 64'd0);
    check("t5_fault_err",  64'(cfg_err), 64'd1);
    run_vector(0, "t5_recover");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
